// File: rtl/base_window_loader_pkg.sv
// Shared definitions for the base window loader: 2-bit base encodings,
// default window length and the sequencing FSM states.
package base_window_loader_pkg;

   localparam logic [1:0] BASE_A = 2'b00;
   localparam logic [1:0] BASE_C = 2'b01;
   localparam logic [1:0] BASE_G = 2'b10;
   localparam logic [1:0] BASE_T = 2'b11;

   localparam int WINDOW_BASES_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_DONE
   } state_t;

   // An ambiguous base occupies its slot as A; the fill count keeps it out of valid windows.
   function automatic logic [1:0] clean_base(input logic [1:0] base, input logic ambiguous);
      return ambiguous ? BASE_A : base;
   endfunction

endpackage

// File: rtl/base_window_loader_window_shift_reg.sv
// Sliding window of 2-bit bases plus a run length of consecutive clean bases;
// flags the cycle after any load/shift that leaves a full clean window.
module base_window_loader_window_shift_reg
   import base_window_loader_pkg::*;
#(
   parameter  int WINDOW_BASES = WINDOW_BASES_DEF,
   localparam int DATA_W       = 2 * WINDOW_BASES,
   localparam int FILL_W       = $clog2(WINDOW_BASES + 1)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              shift,
   input  logic [1:0]        base,
   input  logic              ambiguous,
   output logic [DATA_W-1:0] data,
   output logic              window_full
);

   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WINDOW_BASES);

   logic [FILL_W-1:0] fill_cnt;
   logic [FILL_W-1:0] fill_next;
   logic [DATA_W-1:0] data_next;
   logic [1:0]        sym;

   // NOTE: every signal driven here gets a default first, so no latch is inferred.
   always_comb begin
      sym       = clean_base(base, ambiguous);
      data_next = data;
      fill_next = fill_cnt;
      if (start) begin
         data_next = {{(DATA_W-2){1'b0}}, sym};
         fill_next = ambiguous ? '0 : FILL_W'(1);
      end else if (shift) begin
         data_next = {data[DATA_W-3:0], sym};
         if (ambiguous)
            fill_next = '0;
         else if (fill_cnt != FILL_MAX)
            fill_next = fill_cnt + FILL_W'(1);
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         data        <= '0;
         fill_cnt    <= '0;
         window_full <= 1'b0;
      end else begin
         data        <= data_next;
         fill_cnt    <= fill_next;
         window_full <= (start || shift) && (fill_next == FILL_MAX);
      end
   end

endmodule

// File: rtl/base_window_loader.sv
// Feeds a sliding window of DNA bases to the sequence comparator, tagging each
// full clean window with the position of its oldest base.
module base_window_loader
   import base_window_loader_pkg::*;
#(
   parameter  int WINDOW_BASES = WINDOW_BASES_DEF,
   parameter  int POS_W        = 32,
   localparam int DATA_W       = 2 * WINDOW_BASES
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [1:0]        base_in,
   input  logic              base_n,
   input  logic              base_valid,
   input  logic              base_first,
   input  logic              base_last,
   output logic              base_ready,
   output logic [DATA_W-1:0] data,
   output logic              data_valid,
   output logic [POS_W-1:0]  window_pos,
   output logic              seq_done,
   output logic [POS_W-1:0]  base_count,
   output logic              protocol_err
);

   state_t            state, state_next;
   logic              accept;
   logic              start;
   logic              shift;
   logic              perr_next;
   logic [POS_W-1:0]  accept_cnt, accept_cnt_next;

   assign base_ready = reset_n && (state != ST_DONE);
   assign accept     = base_valid && base_ready;

   always_ff @(posedge clock) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // A base_first beat restarts the sequence from either live state, silently abandoning any run in progress.
   always_comb begin
      state_next      = state;
      start           = 1'b0;
      shift           = 1'b0;
      perr_next       = 1'b0;
      accept_cnt_next = accept_cnt;
      case (state)
         ST_IDLE, ST_STREAM: begin
            if (accept) begin
               if (base_first) begin
                  start           = 1'b1;
                  accept_cnt_next = POS_W'(1);
                  state_next      = base_last ? ST_DONE : ST_STREAM;
               end else if (state == ST_STREAM) begin
                  shift           = 1'b1;
                  accept_cnt_next = accept_cnt + POS_W'(1);
                  if (base_last)
                     state_next = ST_DONE;
               end else begin
                  perr_next = 1'b1;
               end
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         accept_cnt   <= '0;
         window_pos   <= '0;
         seq_done     <= 1'b0;
         base_count   <= '0;
         protocol_err <= 1'b0;
      end else begin
         accept_cnt   <= accept_cnt_next;
         protocol_err <= perr_next;
         seq_done     <= (state_next == ST_DONE);
         if (state_next == ST_DONE)
            base_count <= accept_cnt_next;
         if (start || shift)
            window_pos <= accept_cnt_next - POS_W'(WINDOW_BASES);
      end
   end

   base_window_loader_window_shift_reg #(
      .WINDOW_BASES (WINDOW_BASES)
   ) u_window (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .shift       (shift),
      .base        (base_in),
      .ambiguous   (base_n),
      .data        (data),
      .window_full (data_valid)
   );

endmodule

// File: tb/tb_base_window_loader.sv
// Directed bench for base_window_loader: hand-computed windows and positions,
// plus a small window model checked on every accepted beat.
module tb_base_window_loader;
   import base_window_loader_pkg::*;

   localparam int W = 32;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [1:0]  base_in;
   logic        base_n;
   logic        base_valid;
   logic        base_first;
   logic        base_last;
   logic        base_ready;
   logic [63:0] data;
   logic        data_valid;
   logic [31:0] window_pos;
   logic        seq_done;
   logic [31:0] base_count;
   logic        protocol_err;

   always #5 clock = ~clock;

   base_window_loader #(.WINDOW_BASES(W), .POS_W(32)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .base_in      (base_in),
      .base_n       (base_n),
      .base_valid   (base_valid),
      .base_first   (base_first),
      .base_last    (base_last),
      .base_ready   (base_ready),
      .data         (data),
      .data_valid   (data_valid),
      .window_pos   (window_pos),
      .seq_done     (seq_done),
      .base_count   (base_count),
      .protocol_err (protocol_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic [63:0] pulse_data[$];
   logic [31:0] pulse_pos[$];
   int          n_done;
   int          ready_low;
   int          first_pulse_i;

   // Drive one cycle (inputs set between edges), then sample just after the following falling edge.
   task automatic step(input logic v, input logic [1:0] b, input logic n,
                       input logic f, input logic l, output logic acc);
      base_valid = v;
      base_in    = b;
      base_n     = n;
      base_first = f;
      base_last  = l;
      acc        = v && base_ready;
      @(posedge clock);
      @(negedge clock);
      base_valid = 1'b0;
      base_first = 1'b0;
      base_last  = 1'b0;
      if (!base_ready) ready_low++;
      if (data_valid) begin
         pulse_data.push_back(data);
         pulse_pos.push_back(window_pos);
      end
      if (seq_done) n_done++;
   endtask

   task automatic idle(input int k);
      logic a;
      repeat (k) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, a);
   endtask

   function automatic logic [1:0] pat(input int kind, input int i);
      case (kind)
         0:       return BASE_T;
         1:       return (i < 32) ? BASE_A : BASE_C;
         2:       return 2'(i % 4);
         default: return 2'((i * 3 + 1) % 4);
      endcase
   endfunction

   task automatic run_seq(input int kind, input int len, input int n_idx,
                          input bit gaps, input bit with_last);
      logic [63:0] mwin;
      int          mfill;
      logic        acc;
      logic        n;
      mwin          = '0;
      mfill         = 0;
      first_pulse_i = -1;
      for (int i = 0; i < len; i++) begin
         if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 2)) begin
               step(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, acc);
               check("gap_dv", 64'(data_valid), 64'(0));
               check("gap_hold", data, mwin);
            end
         end
         n = (i == n_idx);
         step(1'b1, pat(kind, i), n, i == 0, with_last && (i == len - 1), acc);
         check("accepted", 64'(acc), 64'(1));
         mwin  = {mwin[61:0], n ? 2'b00 : pat(kind, i)};
         mfill = n ? 0 : ((mfill < W) ? mfill + 1 : W);
         check("dv", 64'(data_valid), 64'(mfill == W));
         check("data", data, mwin);
         if (mfill == W) begin
            check("pos", 64'(window_pos), 64'(32'(i + 1 - W)));
            if (first_pulse_i < 0) first_pulse_i = i;
         end
      end
   endtask

   task automatic clear_pulses();
      pulse_data.delete();
      pulse_pos.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic        acc;
      logic [63:0] held;

      reset_n    = 1'b0;
      base_valid = 1'b1;
      base_in    = BASE_T;
      base_n     = 1'b0;
      base_first = 1'b1;
      base_last  = 1'b0;
      n_done     = 0;
      ready_low  = 0;
      repeat (3) @(negedge clock);
      check("rst_ready", 64'(base_ready), 64'(0));
      check("rst_data", data, 64'(0));
      check("rst_dv", 64'(data_valid), 64'(0));
      check("rst_pos", 64'(window_pos), 64'(0));
      check("rst_done", 64'(seq_done), 64'(0));
      check("rst_count", 64'(base_count), 64'(0));
      check("rst_perr", 64'(protocol_err), 64'(0));
      base_valid = 1'b0;
      base_first = 1'b0;
      reset_n    = 1'b1;
      #1;
      check("rel_ready", 64'(base_ready), 64'(1));

      // 32 T bases: exactly one full window
      clear_pulses();
      n_done = 0;
      run_seq(0, 32, -1, 1'b0, 1'b1);
      check("t32_pulses", 64'(pulse_data.size()), 64'(1));
      if (pulse_data.size() >= 1) begin
         check("t32_data", pulse_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
         check("t32_pos", 64'(pulse_pos[0]), 64'(0));
      end
      check("t32_done", 64'(seq_done), 64'(1));
      check("t32_count", 64'(base_count), 64'(32));
      check("t32_ready", 64'(base_ready), 64'(0));
      idle(1);
      check("t32_ready_back", 64'(base_ready), 64'(1));
      check("t32_done_pulse", 64'(seq_done), 64'(0));
      check("t32_dv_quiet", 64'(data_valid), 64'(0));
      check("t32_ndone", 64'(n_done), 64'(1));

      // 32 A then C: two windows
      clear_pulses();
      run_seq(1, 33, -1, 1'b0, 1'b1);
      check("a33_pulses", 64'(pulse_data.size()), 64'(2));
      if (pulse_data.size() >= 2) begin
         check("a33_data0", pulse_data[0], 64'h0);
         check("a33_pos0", 64'(pulse_pos[0]), 64'(0));
         check("a33_data1", pulse_data[1], 64'h0000_0000_0000_0001);
         check("a33_pos1", 64'(pulse_pos[1]), 64'(1));
      end
      check("a33_count", 64'(base_count), 64'(33));
      idle(1);

      // 50 bases with N at index 10
      clear_pulses();
      run_seq(2, 50, 10, 1'b0, 1'b1);
      check("n50_pulses", 64'(pulse_data.size()), 64'(8));
      check("n50_first_i", 64'(first_pulse_i), 64'(42));
      if (pulse_data.size() == 8) begin
         check("n50_pos_first", 64'(pulse_pos[0]), 64'(11));
         check("n50_pos_last", 64'(pulse_pos[7]), 64'(18));
         check("n50_data_last", pulse_data[7], 64'hB1B1_B1B1_B1B1_B1B1);
      end
      idle(1);

      // beats without base_first in IDLE are dropped
      held = data;
      step(1'b1, BASE_G, 1'b0, 1'b0, 1'b0, acc);
      check("perr_pulse", 64'(protocol_err), 64'(1));
      check("perr_dv", 64'(data_valid), 64'(0));
      check("perr_hold", data, held);
      step(1'b1, BASE_C, 1'b0, 1'b0, 1'b1, acc);
      check("perr_still_idle", 64'(protocol_err), 64'(1));
      check("perr_no_done", 64'(seq_done), 64'(0));
      idle(1);
      check("perr_clear", 64'(protocol_err), 64'(0));
      check("perr_ready", 64'(base_ready), 64'(1));

      // abort at index 20 with a new base_first
      clear_pulses();
      n_done = 0;
      run_seq(2, 20, -1, 1'b0, 1'b0);
      check("abort_no_done", 64'(n_done), 64'(0));
      clear_pulses();
      run_seq(3, 35, -1, 1'b0, 1'b1);
      check("abort_first_i", 64'(first_pulse_i), 64'(31));
      check("abort_pulses", 64'(pulse_data.size()), 64'(4));
      if (pulse_pos.size() >= 1)
         check("abort_pos0", 64'(pulse_pos[0]), 64'(0));
      check("abort_ndone", 64'(n_done), 64'(1));
      check("abort_count", 64'(base_count), 64'(35));
      idle(1);

      // reset mid-sequence
      n_done = 0;
      run_seq(0, 10, -1, 1'b0, 1'b0);
      reset_n = 1'b0;
      idle(1);
      reset_n = 1'b1;
      check("mid_rst_data", data, 64'(0));
      check("mid_rst_pos", 64'(window_pos), 64'(0));
      idle(2);
      check("mid_rst_no_done", 64'(n_done), 64'(0));

      // backpressure gaps in a 40-base sequence
      clear_pulses();
      n_done    = 0;
      ready_low = 0;
      run_seq(3, 40, -1, 1'b1, 1'b1);
      check("bp_count", 64'(base_count), 64'(40));
      idle(3);
      check("bp_pulses", 64'(pulse_data.size()), 64'(9));
      check("bp_ready_low", 64'(ready_low), 64'(1));
      check("bp_ndone", 64'(n_done), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
